arrayofsvi_scan_reader: RTL and testbench
=========================================

// Module: arrayofsvi_scan_reader
// PURPOSE
//  Read-side counterpart to the SVI-array writer: captures a parallel input word
//  into an array of SVI instances, one element per bit, then streams it out
//  serially, LSB first, over a valid/ready handshake.
//  Exercises always_ff writes to, and indexed reads from, scalar members of an
//  SVI array inside a generate loop. Sits between a parallel source and a
//  serial consumer in the interface testcases.
// PARAMETERS
//  SIZE   8                 number of SVI instances (bits per word), >=1
//  IDX_W  max(1,$clog2(SIZE))  width of element index (derived, not overridden)
// PORTS
//  i_clk    input   1       single clock, all state on rising edge
//  i_arst   input   1       asynchronous reset, active-low
//  i_start  input   1       request capture and scan; honoured only in IDLE
//  i_a      input   SIZE    parallel word; i_a[i] -> u_I[i].x
//  i_ready  input   1       consumer accepts o_bit this cycle
//  o_bit    output  1       current serial bit = u_I[o_idx].x in SHIFT, else 0
//  o_valid  output  1       o_bit valid (high throughout SHIFT)
//  o_idx    output  IDX_W   index of the element currently presented
//  o_busy   output  1       high in SHIFT and DONE
//  o_done   output  1       one-cycle pulse after last element accepted
// BEHAVIOUR
//  Interface I_rd: logic x (captured data bit), logic v (element pending).
//  Array u_I[SIZE-1:0] of I_rd; every member written only by always_ff.
//  Reset (i_arst=0, async, any state): state=IDLE, idx=0, all u_I[i].x=0 and
//   u_I[i].v=0; o_bit=o_valid=o_busy=o_done=0, o_idx=0. Mid-scan reset aborts.
//   Outputs drop without waiting for a clock edge.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: i_start=1 at edge -> per i: u_I[i].x<=i_a[i], u_I[i].v<=1; idx<=0;
//   ->SHIFT. i_start=0: stay; array contents held.
//  SHIFT: o_valid=1, o_bit=u_I[idx].x, o_idx=idx (combinational from regs).
//   Transfer = o_valid&&i_ready at edge: u_I[idx].v<=0; if idx==SIZE-1 ->DONE
//   else idx<=idx+1. No transfer: o_bit/o_idx held stable (AXI-style rule).
//  DONE: o_done=1 for exactly one cycle -> IDLE unconditionally.
//  i_start outside IDLE is ignored (no queueing). i_a is sampled only on the
//   accepting edge; later changes have no effect on the scan.
//  Latency: start accepted at edge k -> first o_valid in cycle k+1. With
//   i_ready tied high, last transfer at edge k+SIZE, o_done in cycle k+SIZE+1,
//   next start accepted earliest at edge k+SIZE+2.
//  Invariant: in SHIFT, u_I[j].v==1 exactly for j>=idx; in IDLE all v==0
//   after a completed scan.
//  idx never exceeds SIZE-1; no wrap. SIZE=1: SHIFT lasts until one transfer.
// STRUCTURE
//  Package asvi_rd_pkg: SIZE default, IDX_W function/localparam, state_t enum
//   {IDLE,SHIFT,DONE}.
//  Interface I_rd declared alongside. One genvar loop holds the per-element
//   always_ff blocks. The FSM and idx counter live in the top body.
//  No sub-module: the logic is small enough to keep in one module.
// TESTING
//  T1 i_a=8'hA5, i_ready=1, start pulse -> o_bit 1,0,1,0,0,1,0,1 on
//     o_idx 0..7, o_done high exactly one cycle after idx 7 accepted.
//  T2 backpressure: i_ready=0 for 3 cycles while o_idx=2 -> o_bit/o_idx
//     stable and u_I[2].v stays 1; then resumes at idx 2.
//  T3 i_start re-pulsed mid-SHIFT and i_a changed to 8'hFF -> ignored; stream
//     still matches the originally captured 8'hA5.
//  T4 i_arst=0 at o_idx=4 -> o_valid/o_busy drop with no clock edge, all
//     v=0, idx=0. After release, start with i_a=8'h3C -> fresh scan.
//  T5 start held high continuously -> scans repeat with exactly one IDLE
//     cycle between o_done and the next capture.
//  T6 SIZE=1, i_a=1 -> one transfer with o_bit=1, o_idx=0, then o_done.

Source files
------------

// File: rtl/asvi_rd_pkg.sv
// Shared types and sizing helpers for the SVI-array scan reader.
package asvi_rd_pkg;

    localparam int SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Index width for an n-element array. It is never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/I_rd.sv
// One element of the read array: a captured data bit and its pending flag.
interface I_rd;
    logic x;
    logic v;
endinterface

// File: rtl/arrayofsvi_scan_reader.sv
// Captures a parallel word into an array of I_rd instances, one per bit, then
// streams the bits out LSB first over a valid/ready handshake.
module arrayofsvi_scan_reader
    import asvi_rd_pkg::*;
#(
    parameter  int SIZE  = SIZE_DEFAULT,
    localparam int IDX_W = idx_w(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_start,
    input  logic [SIZE-1:0]  i_a,
    input  logic             i_ready,
    output logic             o_bit,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_busy,
    output logic             o_done
);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             capture;
    logic             xfer;
    logic             last;
    logic [SIZE-1:0]  x_vec;
    logic [SIZE-1:0]  v_vec;
    logic             sel_x;
    logic             sel_v;

    I_rd u_I[SIZE-1:0] ();

    assign capture = (state_q == IDLE) && i_start;
    assign xfer    = o_valid && i_ready;
    assign last    = (idx_q == IDX_W'(SIZE - 1));

    // Per-element capture on start and pending-flag clear on that element's transfer.
    for (genvar i = 0; i < SIZE; i++) begin : g_elem
        always_ff @(posedge i_clk or negedge i_arst) begin
            if (!i_arst) begin
                u_I[i].x <= 1'b0;
                u_I[i].v <= 1'b0;
            end else if (capture) begin
                u_I[i].x <= i_a[i];
                u_I[i].v <= 1'b1;
            end else if (xfer && (idx_q == IDX_W'(i))) begin
                u_I[i].v <= 1'b0;
            end
        end

        // Instance arrays only take constant indices, so flatten for the mux.
        assign x_vec[i] = u_I[i].x;
        assign v_vec[i] = u_I[i].v;
    end

    // Select the element addressed by the current index.
    always_comb begin
        sel_x = 1'b0;
        sel_v = 1'b0;
        for (int unsigned j = 0; j < SIZE; j++) begin
            if (idx_q == IDX_W'(j)) begin
                sel_x = x_vec[j];
                sel_v = v_vec[j];
            end
        end
    end

    // Scan control: the state machine and the element index counter.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (last) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The pending flag of the presented element is always set while in SHIFT,
    // so gating valid with it keeps the handshake tied to the element state.
    assign o_valid = (state_q == SHIFT) && sel_v;
    assign o_bit   = (state_q == SHIFT) && sel_x;
    assign o_idx   = idx_q;
    assign o_busy  = (state_q == SHIFT) || (state_q == DONE);
    assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_arrayofsvi_scan_reader.sv
// Directed bench for arrayofsvi_scan_reader (SIZE=8 plus a SIZE=1 instance).
module tb_arrayofsvi_scan_reader;

    logic       clk = 1'b0;
    logic       arst;
    logic       start, ready;
    logic [7:0] a;
    logic       bit_o, valid_o, busy_o, done_o;
    logic [2:0] idx_o;

    logic       start1, ready1;
    logic [0:0] a1;
    logic       bit1, valid1, busy1, done1;
    logic [0:0] idx1;

    int n_checks = 0;
    int n_pass   = 0;

    // LSB-first streams, written out by hand.
    logic       bits_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       bits_3c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    arrayofsvi_scan_reader #(.SIZE(8)) dut (
        .i_clk(clk), .i_arst(arst), .i_start(start), .i_a(a), .i_ready(ready),
        .o_bit(bit_o), .o_valid(valid_o), .o_idx(idx_o), .o_busy(busy_o), .o_done(done_o)
    );

    arrayofsvi_scan_reader #(.SIZE(1)) dut1 (
        .i_clk(clk), .i_arst(arst), .i_start(start1), .i_a(a1), .i_ready(ready1),
        .o_bit(bit1), .o_valid(valid1), .o_idx(idx1), .o_busy(busy1), .o_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one presented element of the SIZE=8 stream.
    task automatic check_elem(input string tag, input int k, input logic b);
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_idx"},   32'(idx_o),   32'(k));
        check({tag, "_bit"},   32'(bit_o),   32'(b));
    endtask

    initial begin
        arst = 1'b0; start = 1'b0; ready = 1'b0; a = '0;
        start1 = 1'b0; ready1 = 1'b0; a1 = '0;
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_done",  32'(done_o),  32'd0);
        check("rst_idx",   32'(idx_o),   32'd0);
        check("rst_bit",   32'(bit_o),   32'd0);
        check("rst_v",     32'(dut.v_vec), 32'h00);
        step();
        arst = 1'b1;
        step();

        // T1: A5 streamed with ready high.
        a = 8'hA5; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_elem("t1", k, bits_a5[k]);
            step();
        end
        check("t1_done",     32'(done_o),  32'd1);
        check("t1_done_vld", 32'(valid_o), 32'd0);
        check("t1_done_bsy", 32'(busy_o),  32'd1);
        step();
        check("t1_idle_done", 32'(done_o), 32'd0);
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        check("t1_idle_v",    32'(dut.v_vec), 32'h00);

        // T2: backpressure held at index 2.
        a = 8'hA5; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_elem("t2_hold", 2, 1'b1);
            check("t2_v", 32'(dut.v_vec), 32'hFC);
            step();
        end
        ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            check_elem("t2", k, bits_a5[k]);
            step();
        end
        check("t2_done", 32'(done_o), 32'd1);
        step();

        // T3: start and data changes during SHIFT are ignored.
        a = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_elem("t3", k, bits_a5[k]);
            if (k == 1) begin start = 1'b1; a = 8'hFF; end
            if (k == 4) start = 1'b0;
            step();
        end
        start = 1'b0;
        check("t3_done", 32'(done_o), 32'd1);
        step();

        // T4: asynchronous reset at index 4, then a fresh 3C scan.
        a = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_elem("t4_pre", 4, bits_a5[4]);
        #2 arst = 1'b0;
        #1;
        check("t4_valid", 32'(valid_o), 32'd0);
        check("t4_busy",  32'(busy_o),  32'd0);
        check("t4_idx",   32'(idx_o),   32'd0);
        check("t4_v",     32'(dut.v_vec), 32'h00);
        step();
        arst = 1'b1;
        a = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_elem("t4", k, bits_3c[k]);
            step();
        end
        check("t4_done", 32'(done_o), 32'd1);
        step();

        // T5: start held high gives one IDLE cycle between scans.
        a = 8'hA5; start = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            for (int k = 0; k < 8; k++) begin
                check_elem("t5", k, bits_a5[k]);
                step();
            end
            check("t5_done", 32'(done_o), 32'd1);
            step();
            check("t5_idle_busy",  32'(busy_o),  32'd0);
            check("t5_idle_valid", 32'(valid_o), 32'd0);
        end
        step();
        check("t5_restart", 32'(valid_o), 32'd1);
        start = 1'b0;
        for (int k = 0; k < 9; k++) step();

        // T6: single-element instance.
        a1 = 1'b1; start1 = 1'b1; ready1 = 1'b0;
        step();
        start1 = 1'b0;
        check("t6_valid", 32'(valid1), 32'd1);
        check("t6_bit",   32'(bit1),   32'd1);
        check("t6_idx",   32'(idx1),   32'd0);
        step();
        check("t6_hold",  32'(valid1), 32'd1);
        ready1 = 1'b1;
        step();
        check("t6_done",  32'(done1),  32'd1);
        check("t6_dvld",  32'(valid1), 32'd0);
        step();
        check("t6_idle",  32'(busy1),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
